// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score accumulator.
//   score_state_t     - accumulator FSM states
//   BCD_MAX           - saturated score value (four BCD nines)
//   MAX_LEVEL         - highest level; larger requests clamp to this
//   points_for_lines  - maps a line count to its BCD points digit
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_COMMIT
  } score_state_t;

  localparam logic [15:0] BCD_MAX   = 16'h9999;
  localparam logic [3:0]  MAX_LEVEL = 4'd9;

  // Invalid line counts (0, 5..7) map to zero points.
  function automatic logic [3:0] points_for_lines(
    input logic [2:0] lines,
    input logic [3:0] p1,
    input logic [3:0] p2,
    input logic [3:0] p3,
    input logic [3:0] p4
  );
    logic [3:0] pts;
    case (lines)
      3'd1:    pts = p1;
      3'd2:    pts = p2;
      3'd3:    pts = p3;
      3'd4:    pts = p4;
      default: pts = 4'd0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder.
//   a, b  - BCD digits 0..9
//   cin   - carry in
//   sum   - BCD sum digit 0..9
//   cout  - decimal carry out
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj = raw + 5'd6;
    if (raw > 5'd9) begin
      // Skip the six unused binary codes; the wrap into bit 4 is the carry.
      sum  = adj[3:0];
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_accumulator.sv
// score_accumulator: packed-BCD game score with valid/ready line-clear input.
//   clk, rst_n   - clock, asynchronous active-low reset
//   new_game     - synchronous clear, overrides everything but reset
//   req_valid    - line-clear event offered
//   req_ready    - high in IDLE only
//   req_lines    - lines cleared (1..4 valid, others accepted and dropped)
//   req_level    - level 0..9, larger values clamp to 9
//   score        - four packed BCD digits, [3:0] least significant
//   score_upd    - one-cycle pulse when score changes
//   saturated    - high while score is 9999
// Each event adds points*(level+1) by running level+1 passes of a
// digit-serial BCD add over a working copy, then commits it in one write.
module score_accumulator
  import score_pkg::*;
#(
  parameter logic [3:0] POINTS_1 = 4'd1,
  parameter logic [3:0] POINTS_2 = 4'd3,
  parameter logic [3:0] POINTS_3 = 4'd5,
  parameter logic [3:0] POINTS_4 = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_lines,
  input  logic [3:0]  req_level,
  output logic [15:0] score,
  output logic        score_upd,
  output logic        saturated
);

  score_state_t state, state_next;

  logic [15:0] work;
  logic [3:0]  pts;
  logic [3:0]  pass_left;
  logic [1:0]  dig_idx;
  logic        carry;

  logic [3:0]  lvl_clamped;
  logic        lines_ok;
  logic        accept;
  logic [3:0]  cur_a;
  logic [3:0]  cur_b;
  logic        cur_cin;
  logic [3:0]  sum_dig;
  logic        sum_cout;
  logic        last_digit;
  logic        overflow;

  bcd_digit_add u_digit_add (
    .a    (cur_a),
    .b    (cur_b),
    .cin  (cur_cin),
    .sum  (sum_dig),
    .cout (sum_cout)
  );

  assign req_ready = (state == ST_IDLE);

  always_comb begin
    lvl_clamped = (req_level > MAX_LEVEL) ? MAX_LEVEL : req_level;
    lines_ok    = (req_lines >= 3'd1) && (req_lines <= 3'd4);
    accept      = req_valid && req_ready && !new_game;
    cur_a       = work[{dig_idx, 2'b00} +: 4];
    // Points enter at digit 0 only; each pass starts with a clear carry.
    cur_b       = (dig_idx == 2'd0) ? pts : 4'd0;
    cur_cin     = (dig_idx == 2'd0) ? 1'b0 : carry;
    last_digit  = (dig_idx == 2'd3);
    overflow    = last_digit && sum_cout;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept && lines_ok) state_next = ST_ADD;
      ST_ADD:    if (overflow || (last_digit && pass_left == 4'd0)) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (new_game) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score     <= '0;
      score_upd <= 1'b0;
      saturated <= 1'b0;
      work      <= '0;
      pts       <= '0;
      pass_left <= '0;
      dig_idx   <= '0;
      carry     <= 1'b0;
    end else if (new_game) begin
      score     <= '0;
      score_upd <= 1'b0;
      saturated <= 1'b0;
      dig_idx   <= '0;
      carry     <= 1'b0;
    end else begin
      score_upd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && lines_ok) begin
            pts       <= points_for_lines(req_lines, POINTS_1, POINTS_2, POINTS_3, POINTS_4);
            pass_left <= lvl_clamped;
            dig_idx   <= '0;
            carry     <= 1'b0;
            work      <= score;
          end
        end
        ST_ADD: begin
          if (overflow) begin
            work <= BCD_MAX;
          end else begin
            work[{dig_idx, 2'b00} +: 4] <= sum_dig;
            carry   <= sum_cout;
            dig_idx <= dig_idx + 2'd1;
            if (last_digit && pass_left != 4'd0) pass_left <= pass_left - 4'd1;
          end
        end
        ST_COMMIT: begin
          score     <= work;
          saturated <= (work == BCD_MAX);
          score_upd <= (score != BCD_MAX);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_accumulator.sv
// tb_score_accumulator: directed self-checking bench for score_accumulator.
module tb_score_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_game;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_lines;
  logic [3:0]  req_level;
  logic [15:0] score;
  logic        score_upd;
  logic        saturated;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  score_accumulator #(
    .POINTS_1 (4'd1),
    .POINTS_2 (4'd3),
    .POINTS_3 (4'd5),
    .POINTS_4 (4'd8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_game  (new_game),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lines (req_lines),
    .req_level (req_level),
    .score     (score),
    .score_upd (score_upd),
    .saturated (saturated)
  );

  // Offers one event, then waits (bounded) for req_ready to return.
  // upd_at / ready_at are cycle numbers after the accept edge; ready_at=0 on timeout.
  task automatic send_event(input logic [2:0] lines, input logic [3:0] level,
                            output int upd_at, output int upd_cnt,
                            output int ready_at, output logic busy_seen);
    @(negedge clk);
    req_lines = lines; req_level = level; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    busy_seen = !req_ready;
    upd_at = 0; upd_cnt = 0; ready_at = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (score_upd) begin
        upd_cnt++;
        if (upd_at == 0) upd_at = n;
      end
      if (req_ready) begin
        ready_at = n;
        break;
      end
    end
  endtask

  task automatic pulse_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; new_game = 1'b0; req_valid = 1'b0; req_lines = '0; req_level = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (score !== 16'h0000) begin n_err++; $display("FAIL reset_score: got %h expected 0000", score); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_cmp++; if (score_upd !== 1'b0) begin n_err++; $display("FAIL reset_upd: got %b expected 0", score_upd); end
    n_cmp++; if (saturated !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b expected 0", saturated); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int ua, uc, ra; logic busy;
    send_event(3'd1, 4'd0, ua, uc, ra, busy);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got ready=%b expected 0 during ADD", !busy); end
    n_cmp++; if (ua !== 5) begin n_err++; $display("FAIL single_latency: got %0d expected 5", ua); end
    n_cmp++; if (ra !== 5) begin n_err++; $display("FAIL single_ready_back: got %0d expected 5", ra); end
    n_cmp++; if (score !== 16'h0001) begin n_err++; $display("FAIL single_score: got %h expected 0001", score); end
    @(negedge clk);
    n_cmp++; if (score_upd !== 1'b0) begin n_err++; $display("FAIL single_upd_width: got %b expected 0", score_upd); end
    n_cmp++; if (uc !== 1) begin n_err++; $display("FAIL single_upd_count: got %0d expected 1", uc); end
  endtask

  task automatic test_carry();
    int ua, uc, ra; logic busy;
    pulse_new_game();
    n_cmp++; if (score !== 16'h0000) begin n_err++; $display("FAIL carry_clear: got %h expected 0000", score); end
    send_event(3'd4, 4'd9, ua, uc, ra, busy);   // +80
    n_cmp++; if (ua !== 41) begin n_err++; $display("FAIL carry_lvl9_latency: got %0d expected 41", ua); end
    send_event(3'd4, 4'd1, ua, uc, ra, busy);   // +16
    send_event(3'd2, 4'd0, ua, uc, ra, busy);   // +3
    n_cmp++; if (score !== 16'h0099) begin n_err++; $display("FAIL carry_pre: got %h expected 0099", score); end
    send_event(3'd4, 4'd2, ua, uc, ra, busy);   // +24
    n_cmp++; if (ua !== 13) begin n_err++; $display("FAIL carry_latency: got %0d expected 13", ua); end
    n_cmp++; if (score !== 16'h0123) begin n_err++; $display("FAIL carry_score: got %h expected 0123", score); end
    n_cmp++; if (saturated !== 1'b0) begin n_err++; $display("FAIL carry_sat: got %b expected 0", saturated); end
  endtask

  task automatic test_saturate();
    int ua, uc, ra; logic busy;
    pulse_new_game();
    for (int i = 0; i < 124; i++) send_event(3'd4, 4'd9, ua, uc, ra, busy); // 9920
    send_event(3'd3, 4'd9, ua, uc, ra, busy);   // +50
    send_event(3'd4, 4'd1, ua, uc, ra, busy);   // +16
    send_event(3'd2, 4'd0, ua, uc, ra, busy);   // +3
    send_event(3'd1, 4'd0, ua, uc, ra, busy);   // +1
    n_cmp++; if (score !== 16'h9990) begin n_err++; $display("FAIL sat_pre: got %h expected 9990", score); end
    // 9990+8=9998, then +8 overflows at digit 3 of pass 2 (edge 8); commit at edge 9.
    send_event(3'd4, 4'd9, ua, uc, ra, busy);
    n_cmp++; if (ua !== 9) begin n_err++; $display("FAIL sat_early_commit: got %0d expected 9", ua); end
    n_cmp++; if (score !== 16'h9999) begin n_err++; $display("FAIL sat_score: got %h expected 9999", score); end
    n_cmp++; if (saturated !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b expected 1", saturated); end
    send_event(3'd1, 4'd0, ua, uc, ra, busy);
    n_cmp++; if (uc !== 0) begin n_err++; $display("FAIL sat_no_upd: got %0d pulses expected 0", uc); end
    n_cmp++; if (ra !== 5) begin n_err++; $display("FAIL sat_ready_back: got %0d expected 5", ra); end
    n_cmp++; if (score !== 16'h9999) begin n_err++; $display("FAIL sat_hold: got %h expected 9999", score); end
  endtask

  task automatic test_new_game();
    int upds = 0;
    @(negedge clk);
    req_lines = 3'd1; req_level = 4'd5; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    n_cmp++; if (score !== 16'h0000) begin n_err++; $display("FAIL ng_score: got %h expected 0000", score); end
    n_cmp++; if (saturated !== 1'b0) begin n_err++; $display("FAIL ng_sat: got %b expected 0", saturated); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ng_ready: got %b expected 1", req_ready); end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (score_upd) upds++;
    end
    n_cmp++; if (upds !== 0) begin n_err++; $display("FAIL ng_no_upd: got %0d pulses expected 0", upds); end
    // Event offered in the same cycle as new_game is ignored.
    req_lines = 3'd1; req_level = 4'd0; req_valid = 1'b1; new_game = 1'b1;
    @(negedge clk); req_valid = 1'b0; new_game = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ng_valid_ignored: got ready=%b expected 1", req_ready); end
    repeat (8) @(negedge clk);
    n_cmp++; if (score !== 16'h0000) begin n_err++; $display("FAIL ng_valid_score: got %h expected 0000", score); end
  endtask

  task automatic test_level_clamp();
    int ua, uc, ra; logic busy;
    send_event(3'd1, 4'd15, ua, uc, ra, busy);
    n_cmp++; if (ua !== 41) begin n_err++; $display("FAIL clamp_latency: got %0d expected 41", ua); end
    n_cmp++; if (score !== 16'h0010) begin n_err++; $display("FAIL clamp_score: got %h expected 0010", score); end
  endtask

  task automatic test_back_to_back();
    int u1 = 0, u2 = 0;
    logic [15:0] s1 = '0, s2 = '0;
    logic rdy6 = 1'b1;
    pulse_new_game();
    @(negedge clk);
    req_lines = 3'd2; req_level = 4'd0; req_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (score_upd) begin
        if (u1 == 0) begin u1 = n; s1 = score; end
        else if (u2 == 0) begin u2 = n; s2 = score; end
      end
      if (n == 6) begin rdy6 = req_ready; req_valid = 1'b0; end
    end
    n_cmp++; if (u1 !== 5) begin n_err++; $display("FAIL b2b_first_at: got %0d expected 5", u1); end
    n_cmp++; if (s1 !== 16'h0003) begin n_err++; $display("FAIL b2b_first_score: got %h expected 0003", s1); end
    n_cmp++; if (rdy6 !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: got ready=%b expected 0", rdy6); end
    n_cmp++; if (u2 !== 11) begin n_err++; $display("FAIL b2b_second_at: got %0d expected 11", u2); end
    n_cmp++; if (s2 !== 16'h0006) begin n_err++; $display("FAIL b2b_second_score: got %h expected 0006", s2); end
  endtask

  task automatic test_dropped();
    logic [2:0] lines_tab [2];
    int low_cnt = 0, upds = 0;
    lines_tab[0] = 3'd0; lines_tab[1] = 3'd6;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_lines = lines_tab[k]; req_level = 4'd3; req_valid = 1'b1;
      if (!req_ready) low_cnt++;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      for (int n = 0; n < 6; n++) begin
        if (!req_ready) low_cnt++;
        if (score_upd) upds++;
        @(negedge clk);
      end
    end
    n_cmp++; if (low_cnt !== 0) begin n_err++; $display("FAIL drop_ready: got %0d low samples expected 0", low_cnt); end
    n_cmp++; if (upds !== 0) begin n_err++; $display("FAIL drop_no_upd: got %0d pulses expected 0", upds); end
    n_cmp++; if (score !== 16'h0006) begin n_err++; $display("FAIL drop_score: got %h expected 0006", score); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_lines = 3'd4; req_level = 4'd9; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b expected 0", req_ready); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (score !== 16'h0000) begin n_err++; $display("FAIL arst_score: got %h expected 0000", score); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b expected 1", req_ready); end
    n_cmp++; if (score_upd !== 1'b0) begin n_err++; $display("FAIL arst_upd: got %b expected 0", score_upd); end
    n_cmp++; if (saturated !== 1'b0) begin n_err++; $display("FAIL arst_sat: got %b expected 0", saturated); end
    @(negedge clk); rst_n = 1'b1;
    repeat (50) @(negedge clk);
    n_cmp++; if (score !== 16'h0000) begin n_err++; $display("FAIL arst_discard: got %h expected 0000", score); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_saturate();
    test_new_game();
    test_level_clamp();
    test_back_to_back();
    test_dropped();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
